// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle SLL/SRL/SRA for the RV32I execute stage.
// Shifts at most SHIFT_STEP bits per cycle, so a shift by shamt costs
// 1 + ceil(shamt/SHIFT_STEP) edges, counting the accept edge.
module iter_shift_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] operand_i,
    input  logic [4:0]      shamt_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    // Elaboration-time parameter guards
    if (XLEN != 32) begin : g_bad_xlen
        $error("iter_shift_unit: only XLEN=32 is supported");
    end
    if (SHIFT_STEP != 1 && SHIFT_STEP != 2 && SHIFT_STEP != 4 &&
        SHIFT_STEP != 8 && SHIFT_STEP != 16) begin : g_bad_step
        $error("iter_shift_unit: SHIFT_STEP must be 1, 2, 4, 8 or 16");
    end

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   data;
    logic [1:0]        op;
    logic [4:0]        cnt;
    logic [4:0]        k;
    logic [XLEN-1:0]   shifted;
    logic              accept;

    // A request arriving together with a flush is dropped
    assign accept   = valid_i && ready_o && !flush_i;
    assign ready_o  = (state == IDLE);
    assign busy_o   = (state != IDLE);
    assign valid_o  = (state == DONE);
    assign result_o = data;

    // Step size this cycle: the remaining count, capped at SHIFT_STEP
    always_comb begin
        k = (cnt < STEP) ? cnt : STEP;
    end

    // One fixed-range shift step; SRA refills from the current sign bit
    always_comb begin
        shifted = data;
        case (op)
            2'b00:   shifted = data << k;
            2'b01:   shifted = data >> k;
            2'b10:   shifted = XLEN'($signed(data) >>> k);
            default: shifted = data;
        endcase
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (shamt_i == 5'd0 || op_i == 2'b11) state_nxt = DONE;
                    else                                  state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == k) state_nxt = DONE;
            end
            DONE: begin
                if (ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_i) state_nxt = IDLE;
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    // Operand capture on accept, then one shift step per SHIFT cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data <= '0;
            op   <= 2'b00;
            cnt  <= 5'd0;
        end else if (accept) begin
            data <= operand_i;
            op   <= op_i;
            cnt  <= shamt_i;
        end else if (state == SHIFT && !flush_i) begin
            data <= shifted;
            cnt  <= cnt - k;
        end
    end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Scoreboard bench for iter_shift_unit: two instances (SHIFT_STEP 1 and 4)
// share stimulus, a driver pushes expected results, a monitor pops and checks.
module tb_iter_shift_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, valid, rdy_in, sel;
    logic [1:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;

    logic [1:0]       rdy_o, vld_o, bsy;
    logic [1:0][31:0] res;
    logic             rdy_m, vld_m, bsy_m;
    logic [31:0]      res_m;

    assign rdy_m = rdy_o[sel];
    assign vld_m = vld_o[sel];
    assign bsy_m = bsy[sel];
    assign res_m = res[sel];

    iter_shift_unit #(.XLEN(32), .SHIFT_STEP(1)) u_s1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .valid_i(valid && !sel), .ready_o(rdy_o[0]),
        .op_i(op), .operand_i(operand), .shamt_i(shamt),
        .valid_o(vld_o[0]), .ready_i(rdy_in),
        .result_o(res[0]), .busy_o(bsy[0])
    );

    iter_shift_unit #(.XLEN(32), .SHIFT_STEP(4)) u_s4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .valid_i(valid && sel), .ready_o(rdy_o[1]),
        .op_i(op), .operand_i(operand), .shamt_i(shamt),
        .valid_o(vld_o[1]), .ready_i(rdy_in),
        .result_o(res[1]), .busy_o(bsy[1])
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    logic in_res = 1'b0;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: RV32I shift semantics on whole words
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s);
        case (o)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b10:   return 32'($signed(a) >>> s);
            default: return a;
        endcase
    endfunction

    function automatic int latency(input logic [1:0] o, input logic [4:0] s, input logic sl);
        int step;
        step = sl ? 4 : 1;
        if (o == 2'b11 || s == 5'd0) return 1;
        return 1 + (int'(s) + step - 1) / step;
    endfunction

    // Monitor: checks each presented result and the handshake state
    always @(negedge clk) begin
        #2;
        if (vld_m) begin
            if (!in_res) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 32'(vld_m), 32'd0);
                end else begin
                    cur = q.pop_front();
                    chk("result", res_m, cur.res);
                    chk("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
                    in_res = 1'b1;
                end
            end else begin
                chk("hold_stable", res_m, cur.res);
            end
            chk("ready_in_done", {30'd0, bsy_m, rdy_m}, 32'd2);
            if (rdy_in && !flush) in_res = 1'b0;
        end else if (in_res) begin
            chk("valid_dropped", 32'(vld_m), 32'd1);
            in_res = 1'b0;
        end else if (q.size() > 0) begin
            chk("busy_in_flight", {30'd0, bsy_m, rdy_m}, 32'd2);
        end else begin
            chk("idle_state", {30'd0, bsy_m, rdy_m}, 32'd1);
        end
    end

    // Issue one operation from a negedge with the unit idle; returns at a
    // negedge after the result has been taken
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s, input int hold);
        exp_t e;
        int   n;
        valid = 1'b1; op = o; operand = a; shamt = s;
        @(posedge clk); #1;
        e.res = model(o, a, s);
        e.lat = latency(o, s, sel);
        e.acc = cyc;
        q.push_back(e);
        @(negedge clk);
        valid = 1'b0; op = 2'($urandom); operand = $urandom; shamt = 5'($urandom);
        if (hold == 0) rdy_in = 1'b1;
        n = 0;
        while (!vld_m && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!vld_m) begin
            chk("timeout", 32'd0, 32'd1);
            rdy_in = 1'b0;
            return;
        end
        repeat (hold) @(negedge clk);
        rdy_in = 1'b1;
        @(negedge clk);
        rdy_in = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; rdy_in = 1'b0; sel = 1'b0;
        op = 2'b00; operand = 32'd0; shamt = 5'd0;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("reset_flags", {29'd0, vld_o[i], bsy[i], rdy_o[i]}, 32'd1);
            chk("reset_result", res[i], 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases on the single-bit-step instance
        run_op(2'b00, 32'h0000_0001, 5'd31, 0);
        run_op(2'b10, 32'h8000_0000, 5'd4, 0);
        run_op(2'b01, 32'h8000_0000, 5'd4, 1);
        run_op(2'b10, 32'h7FFF_FFF0, 5'd4, 0);
        run_op(2'b00, 32'hDEAD_BEEF, 5'd0, 0);
        run_op(2'b11, 32'hDEAD_BEEF, 5'd7, 0);
        run_op(2'b10, 32'h8000_0001, 5'd9, 3);
        run_op(2'b01, 32'h1234_5678, 5'd8, 0);

        // Flush at cnt=10 of SLL by 20, with a competing request
        valid = 1'b1; op = 2'b00; operand = 32'h0000_0001; shamt = 5'd20;
        @(posedge clk); #1;
        q.push_back('{res: 32'h0010_0000, lat: 21, acc: cyc});
        @(negedge clk);
        valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1; valid = 1'b1; operand = 32'hFFFF_FFFF; shamt = 5'd3;
        @(negedge clk);
        flush = 1'b0; valid = 1'b0;
        void'(q.pop_back());
        chk("flush_idle", {29'd0, vld_m, bsy_m, rdy_m}, 32'd1);
        repeat (30) @(negedge clk);

        // Asynchronous reset mid-shift
        valid = 1'b1; op = 2'b01; operand = 32'hFFFF_0000; shamt = 5'd25;
        @(posedge clk); #1;
        q.push_back('{res: 32'h0000_007F, lat: 26, acc: cyc});
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(q.pop_back());
        chk("async_reset_flags", {29'd0, vld_m, bsy_m, rdy_m}, 32'd1);
        chk("async_reset_result", res_m, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'b01, 32'hF000_0000, 5'd28, 0);

        // Step-4 instance
        sel = 1'b1;
        @(negedge clk);
        run_op(2'b00, 32'h0000_0001, 5'd5, 0);
        run_op(2'b10, 32'h8000_0000, 5'd31, 2);

        // Randomized traffic on both instances
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            @(negedge clk);
            for (int i = 0; i < 30; i++) begin
                run_op(2'($urandom), $urandom, 5'($urandom), int'($urandom_range(0, 3)));
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/iter_shift_unit.md
# iter_shift_unit

Multi-cycle shift unit for the RV32I execute stage. Performs SLL/SRL/SRA by sequencing a small fixed-step shift datapath over several cycles instead of a full barrel shifter. It accepts one operation at a time over a valid/ready handshake and holds the result until the writeback side takes it. It trades latency for area on FPGA builds where the single-cycle shifter is too large.

## Interface
- XLEN, 32: operand/result width; only 32 is supported.
- SHIFT_STEP, 1: maximum bits shifted per cycle; legal values 1, 2, 4, 8, 16.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- flush_i  in  1  synchronous abort of any in-flight operation (pipeline flush).
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request.
- op_i  in  2  00 SLL, 01 SRL, 10 SRA, 11 reserved.
- operand_i  in  XLEN  value to shift (rs1).
- shamt_i  in  5  shift amount (rs2[4:0] / imm[4:0]).
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- result_o  out  XLEN  shifted value.
- busy_o  out  1  operation in flight (state != IDLE).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: ready_o=1. On valid_i && ready_o, latch operand_i into the data register, op_i into the op register, and shamt_i into the 5-bit counter cnt.
  - If shamt_i==0 or op_i==11, go to DONE; the result is operand_i unchanged.
  - Otherwise go to SHIFT.
- SHIFT: each cycle, k = min(cnt, SHIFT_STEP); shift the data register by k; cnt -= k. When cnt-k==0, go to DONE.
  - SLL fills with zeros. SRL fills with zeros. SRA fills with data[31] of the current register (sign preserved across steps).
- DONE: valid_o=1 and result_o = data register. On ready_i, go to IDLE. Otherwise hold result_o and valid_o stable.
- ready_o=1 only in IDLE; no accept in SHIFT or DONE.
- busy_o = (state != IDLE).
- flush_i has priority over every transition: the next state is IDLE and valid_o drops the next cycle. A valid_i in the same cycle as flush_i is not accepted.
- Inputs are sampled only on the accept edge; later changes to operand_i, shamt_i or op_i have no effect.

## Timing
- Reset (rst_ni=0, asynchronous): state=IDLE, cnt=0, data=0, op=00. Therefore valid_o=0, result_o=0, busy_o=0, ready_o=1.
- Latency: L = 1 + ceil(shamt/SHIFT_STEP) rising edges, counting the accept edge. valid_o is high in the cycle after the L-th edge.
  - shamt=0 or op=11: valid_o is high the cycle after accept.
  - SHIFT_STEP=1, shamt=31: 32 edges.
  - SHIFT_STEP=4, shamt=5: 3 edges (steps of 4 then 1).
- Handshake rules:
  - Accept occurs on an edge with valid_i && ready_o.
  - A result transfers on an edge with valid_o && ready_i. ready_o rises in the following cycle.
  - Peak throughput is one operation per L+1 cycles.
- If ready_i is high on entry to DONE, valid_o is high for exactly one cycle.
- Reset mid-operation aborts immediately, with the asynchronous reset values above; no partial result is presented.
- flush_i in DONE with ready_i also high: flush wins, and the result is not counted as transferred.

## Test plan
- Reset then idle: rst_ni low, then high → ready_o=1, valid_o=0, result_o=0x00000000, busy_o=0.
- SLL, SHIFT_STEP=1: operand 0x00000001, shamt 31 → result_o=0x80000000. valid_o rises exactly 32 edges after accept; busy_o is high throughout.
- SRA vs SRL: operand 0x80000000, shamt 4.
  - SRA → 0xF8000000.
  - SRL → 0x08000000.
  - SRA of 0x7FFFFFF0 by 4 → 0x07FFFFFF.
- Zero shift, reserved op, and STEP=4:
  - shamt 0 on 0xDEADBEEF → 0xDEADBEEF one cycle after accept.
  - op=11 with shamt 7 → 0xDEADBEEF, same latency.
  - SHIFT_STEP=4, SLL 0x1 by 5 → 0x00000020 after 3 edges.
- Backpressure: hold ready_i=0 for 3 cycles in DONE → valid_o and result_o stable and ready_o=0 for all 3 cycles. Raising ready_i returns the unit to IDLE, and a back-to-back request is accepted the following cycle.
- Abort cases:
  - flush_i at cnt=10 of SLL by 20 → IDLE next edge; valid_o never rises.
  - rst_ni pulsed low mid-SHIFT → asynchronous return to reset values.
  - A new request afterward (SRL 0xF0000000 by 28) → 0x0000000F.
